// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of ID predictions, checked against EX outcomes at pop.
// Redirect is registered one cycle after the mispredicting pop; no backpressure, overflow/underflow raise sync_err.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [31:0]      id_pc,
  input  logic             id_pred_taken,
  input  logic [31:0]      id_pred_target,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_br_inst,
  input  logic             ex_is_uncond,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_target,
  input  logic             wb_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             sync_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_t;

  pred_t         q [DEPTH];
  pred_t         head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, empty, full;
  logic          actual_taken, head_pc_bad, mispredict;
  logic          do_push, do_pop;

  always_comb begin
    head         = q[rd_ptr];
    empty        = (count == '0);
    full         = (count == FULL_CNT);
    push         = id_valid && !id_stall && !wb_flush && !redirect_valid;
    pop          = ex_valid && !wb_flush && !redirect_valid;
    actual_taken = ex_is_uncond || (ex_br_inst && ex_br_taken);
    head_pc_bad  = !empty && (head.pc != ex_pc);
    // An empty pop has no valid head, so it always takes the error/redirect path.
    mispredict   = pop && (empty || head_pc_bad
                   || (head.pred_taken != actual_taken)
                   || (actual_taken && (head.pred_target != ex_target)));
    do_push      = push && (!full || pop);
    do_pop       = pop && !empty;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      q[wr_ptr] <= '{pc: id_pc, pred_taken: id_pred_taken, pred_target: id_pred_target};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_cnt         <= '0;
      mispred_cnt    <= '0;
      sync_err       <= 1'b0;
    end else begin
      // Flush or mispredict discards every queued wrong-path prediction, including this cycle's push.
      if (wb_flush || mispredict) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end

      redirect_valid <= mispredict;
      if (mispredict) begin
        redirect_pc <= actual_taken ? ex_target : ex_pc + 32'd4;
      end

      if (pop && (ex_br_inst || ex_is_uncond) && (br_cnt != '1)) begin
        br_cnt <= br_cnt + 1'b1;
      end
      if (mispredict && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + 1'b1;
      end

      if ((push && full && !pop) || (pop && empty) || (pop && head_pc_bad)) begin
        sync_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: 32-bit and 4-bit-counter instances share all stimulus.
module tb_branch_resolve_unit;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_stall, id_pred_taken;
  logic [31:0] id_pc, id_pred_target;
  logic        ex_valid, ex_br_inst, ex_is_uncond, ex_br_taken;
  logic [31:0] ex_pc, ex_target;
  logic        wb_flush;

  logic        rv, se, rv4, se4;
  logic [31:0] rpc, rpc4, bc32, mc32;
  logic [3:0]  bc4, mc4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_inst(ex_br_inst),
    .ex_is_uncond(ex_is_uncond), .ex_br_taken(ex_br_taken), .ex_target(ex_target),
    .wb_flush(wb_flush),
    .redirect_valid(rv), .redirect_pc(rpc), .br_cnt(bc32), .mispred_cnt(mc32), .sync_err(se)
  );

  branch_resolve_unit #(.DEPTH(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_inst(ex_br_inst),
    .ex_is_uncond(ex_is_uncond), .ex_br_taken(ex_br_taken), .ex_target(ex_target),
    .wb_flush(wb_flush),
    .redirect_valid(rv4), .redirect_pc(rpc4), .br_cnt(bc4), .mispred_cnt(mc4), .sync_err(se4)
  );

  typedef struct {
    logic        idv, ids;
    logic [31:0] idpc;
    logic        idpt;
    logic [31:0] idtg;
    logic        exv;
    logic [31:0] expc;
    logic        exbr, exun, extk;
    logic [31:0] extg;
    logic        wbf;
    logic        rv;
    logic [31:0] rpc, bc, mc;
    logic        se;
  } vec_t;

  vec_t vq[$];

  task automatic drive(input vec_t v);
    id_valid       = v.idv;
    id_stall       = v.ids;
    id_pc          = v.idpc;
    id_pred_taken  = v.idpt;
    id_pred_target = v.idtg;
    ex_valid       = v.exv;
    ex_pc          = v.expc;
    ex_br_inst     = v.exbr;
    ex_is_uncond   = v.exun;
    ex_br_taken    = v.extk;
    ex_target      = v.extg;
    wb_flush       = v.wbf;
  endtask

  // The 4-bit instance must match everything except that its counters saturate at 15.
  task automatic check(input string tag, input logic erv, input logic [31:0] erpc,
                       input logic [31:0] ebc, input logic [31:0] emc, input logic ese);
    logic [3:0] ebc4, emc4;
    ebc4 = (ebc > 32'd15) ? 4'hf : ebc[3:0];
    emc4 = (emc > 32'd15) ? 4'hf : emc[3:0];
    n_vec++;
    if (rv !== erv || rpc !== erpc || bc32 !== ebc || mc32 !== emc || se !== ese ||
        rv4 !== erv || rpc4 !== erpc || se4 !== ese || bc4 !== ebc4 || mc4 !== emc4) begin
      n_err++;
      $display("FAIL %s: got rv=%0b rpc=%h br=%0d mp=%0d serr=%0b | cnt4 br=%0d mp=%0d rv4=%0b rpc4=%h serr4=%0b ; want rv=%0b rpc=%h br=%0d mp=%0d serr=%0b cnt4 br=%0d mp=%0d",
               tag, rv, rpc, bc32, mc32, se, bc4, mc4, rv4, rpc4, se4,
               erv, erpc, ebc, emc, ese, ebc4, emc4);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check(tag, v.rv, v.rpc, v.bc, v.mc, v.se);
  endtask

  task automatic do_reset();
    vec_t z;
    z = '{default: '0};
    drive(z);
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("reset_state", N, 32'h0, 32'd0, 32'd0, N);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vec_t v;
    int   bc, mc;
    logic [31:0] tgt;

    //              idv ids idpc         idpt idtg        exv expc         br un tk extg        wbf  rv rpc          bc     mc     se
    vq.push_back('{Y, N, 32'h100, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h0,   32'd0, 32'd0, N});
    vq.push_back('{Y, Y, 32'h666, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h0,   32'd0, 32'd0, N});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'h100, Y, N, N, 32'h140, N,  N, 32'h0,   32'd1, 32'd0, N});
    vq.push_back('{Y, N, 32'h200, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h0,   32'd1, 32'd0, N});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'h200, Y, N, Y, 32'h240, N,  Y, 32'h240, 32'd2, 32'd1, N});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h240, 32'd2, 32'd1, N});
    vq.push_back('{Y, N, 32'h300, Y, 32'h380, N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h240, 32'd2, 32'd1, N});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'h300, Y, N, Y, 32'h390, N,  Y, 32'h390, 32'd3, 32'd2, N});
    vq.push_back('{Y, N, 32'h999, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h390, 32'd3, 32'd2, N});
    vq.push_back('{Y, N, 32'h304, Y, 32'h500, N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h390, 32'd3, 32'd2, N});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'h304, N, N, N, 32'h0,   N,  Y, 32'h308, 32'd3, 32'd3, N});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h308, 32'd3, 32'd3, N});
    vq.push_back('{Y, N, 32'h400, Y, 32'h800, N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h308, 32'd3, 32'd3, N});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'h400, N, Y, N, 32'h800, N,  N, 32'h308, 32'd4, 32'd3, N});
    vq.push_back('{Y, N, 32'h500, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h308, 32'd4, 32'd3, N});
    vq.push_back('{Y, N, 32'h504, N, 32'h0,   Y, 32'h500, Y, N, Y, 32'h600, N,  Y, 32'h600, 32'd5, 32'd4, N});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h600, 32'd5, 32'd4, N});
    vq.push_back('{Y, N, 32'h700, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h600, 32'd5, 32'd4, N});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'h700, Y, N, N, 32'h0,   N,  N, 32'h600, 32'd6, 32'd4, N});
    // Fill to DEPTH (wrapping the write pointer), overflow, then push+pop while full.
    vq.push_back('{Y, N, 32'hA00, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h600, 32'd6, 32'd4, N});
    vq.push_back('{Y, N, 32'hA04, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h600, 32'd6, 32'd4, N});
    vq.push_back('{Y, N, 32'hA08, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h600, 32'd6, 32'd4, N});
    vq.push_back('{Y, N, 32'hA0C, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h600, 32'd6, 32'd4, N});
    vq.push_back('{Y, N, 32'hA10, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'h600, 32'd6, 32'd4, Y});
    vq.push_back('{Y, N, 32'hA14, N, 32'h0,   Y, 32'hA00, Y, N, N, 32'h0,   N,  N, 32'h600, 32'd7, 32'd4, Y});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'hA04, Y, N, N, 32'h0,   N,  N, 32'h600, 32'd8, 32'd4, Y});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'hA08, Y, N, N, 32'h0,   N,  N, 32'h600, 32'd9, 32'd4, Y});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'hA0C, Y, N, N, 32'h0,   N,  N, 32'h600, 32'd10, 32'd4, Y});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'hA14, Y, N, N, 32'h0,   N,  N, 32'h600, 32'd11, 32'd4, Y});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'hB00, Y, N, N, 32'h0,   N,  Y, 32'hB04, 32'd12, 32'd5, Y});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'hB04, 32'd12, 32'd5, Y});
    // Mispredict coinciding with wb_flush: no redirect, no counting, queue cleared.
    vq.push_back('{Y, N, 32'hC00, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'hB04, 32'd12, 32'd5, Y});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'hC00, Y, N, Y, 32'hC80, Y,  N, 32'hB04, 32'd12, 32'd5, Y});
    vq.push_back('{Y, N, 32'hD00, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'hB04, 32'd12, 32'd5, Y});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'hD00, Y, N, N, 32'h0,   N,  N, 32'hB04, 32'd13, 32'd5, Y});
    vq.push_back('{Y, N, 32'hE00, N, 32'h0,   N, 32'h0,   N, N, N, 32'h0,   N,  N, 32'hB04, 32'd13, 32'd5, Y});
    vq.push_back('{N, N, 32'h0,   N, 32'h0,   Y, 32'hE00, Y, N, Y, 32'hE40, N,  Y, 32'hE40, 32'd14, 32'd6, Y});

    do_reset();
    foreach (vq[i]) apply(vq[i], $sformatf("tbl%0d", i));

    // Asynchronous reset while redirect_valid is high clears everything without a clock edge.
    #2 rst = 1'b0;
    #1 check("rst_mid_redirect", N, 32'h0, 32'd0, 32'd0, N);
    @(negedge clk);
    v = '{default: '0};
    drive(v);
    rst = 1'b1;

    // Pop on empty queue: sync error plus redirect to fall-through.
    v = '{default: '0};
    v.exv = Y; v.expc = 32'h40; v.exbr = Y;
    v.rv = Y; v.rpc = 32'h44; v.bc = 32'd1; v.mc = 32'd1; v.se = Y;
    apply(v, "empty_pop");

    bc  = 1;
    mc  = 1;
    tgt = 32'h44;
    for (int i = 0; i < 20; i++) begin
      v = '{default: '0};
      v.rpc = tgt; v.bc = 32'(bc); v.mc = 32'(mc); v.se = Y;
      apply(v, $sformatf("sat_idle%0d", i));
      v.idv = Y; v.idpc = 32'h1000 + 32'(i * 16);
      apply(v, $sformatf("sat_push%0d", i));
      bc++;
      mc++;
      tgt = 32'h2000 + 32'(i * 16);
      v = '{default: '0};
      v.exv = Y; v.expc = 32'h1000 + 32'(i * 16); v.exbr = Y; v.extk = Y; v.extg = tgt;
      v.rv = Y; v.rpc = tgt; v.bc = 32'(bc); v.mc = 32'(mc); v.se = Y;
      apply(v, $sformatf("sat_pop%0d", i));
    end

    n_vec++;
    if (mc4 !== 4'hf || bc4 !== 4'hf || mc32 !== 32'd21 || bc32 !== 32'd21) begin
      n_err++;
      $display("FAIL sat_final: got mp4=%0d br4=%0d mp32=%0d br32=%0d want 15 15 21 21",
               mc4, bc4, mc32, bc32);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
